// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep capture block.
// The optional popcount is enabled by defining TT_SWEEP_CAPTURE_POPCOUNT_EN.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NIN_DEF    = 7;
    localparam int SETTLE_DEF = 0;
    localparam int SETTLE_W   = 4;

endpackage

// File: rtl/tt_sweep_fsm.sv
// Sweep sequencer: walks idx through every input vector, dwelling SETTLE+1
// cycles on each, and strobes the capture stage at the end of each dwell.
module tt_sweep_fsm
    import tt_sweep_pkg::*;
#(
    parameter int NIN    = NIN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           ack,
    output logic           clear,
    output logic           sample,
    output logic           last,
    output logic           busy,
    output logic [NIN-1:0] x_o
);

    localparam logic [NIN-1:0]      IDX_ONE  = NIN'(1);
    localparam logic [NIN-1:0]      IDX_LAST = '1;
    localparam logic [SETTLE_W-1:0] W_ONE    = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] W_TOP    = SETTLE_W'(SETTLE);

    state_t              state;
    state_t              state_nxt;
    logic [NIN-1:0]      idx;
    logic [SETTLE_W-1:0] wcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = HOLD;
            HOLD:    if (ack)   state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clear  = (state == IDLE) && start;
        sample = (state == RUN) && (wcnt == W_TOP);
        last   = sample && (idx == IDX_LAST);
        busy   = (state != IDLE);
    end

    // idx wraps to 0 on the final sample, so x_o already reads 0 in HOLD/IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            wcnt <= '0;
        end else if (clear) begin
            idx  <= '0;
            wcnt <= '0;
        end else if (state == RUN) begin
            if (sample) begin
                idx  <= idx + IDX_ONE;
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + W_ONE;
            end
        end
    end

    assign x_o = idx;

endmodule

// File: rtl/tt_sweep_capture.sv
// Truth-table capture stage: drives every input vector, records f_i per vector
// and offers the table downstream. TT_SWEEP_CAPTURE_POPCOUNT_EN adds ones_o.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int NIN    = NIN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic [NIN-1:0]        x_o,
    input  logic                  f_i,
    output logic [(1<<NIN)-1:0]   tt_o,
    output logic                  tt_valid,
    input  logic                  tt_ready
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
    ,
    output logic [NIN:0]          ones_o
`endif
);

    logic clear;
    logic sample;
    logic last;
    logic ack;

    assign ack = tt_valid && tt_ready;

    tt_sweep_fsm #(
        .NIN    (NIN),
        .SETTLE (SETTLE)
    ) u_fsm (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ack    (ack),
        .clear  (clear),
        .sample (sample),
        .last   (last),
        .busy   (busy),
        .x_o    (x_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      tt_o <= '0;
        else if (clear)  tt_o <= '0;
        else if (sample) tt_o[x_o] <= f_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tt_valid <= 1'b0;
        else if (last) tt_valid <= 1'b1;
        else if (ack)  tt_valid <= 1'b0;
    end

`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
    localparam logic [NIN:0] ONES_ONE = (NIN+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ones_o <= '0;
        else if (clear)          ones_o <= '0;
        else if (sample && f_i)  ones_o <= ones_o + ONES_ONE;
    end
`endif

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench: default instance with selectable function, plus a SETTLE=3 instance.
module tb_tt_sweep_capture;

    logic         clk;
    logic         rst_n;

    logic         start0, ready0, f0, busy0, valid0;
    logic [6:0]   x0;
    logic [127:0] tt0;
    logic         start1, ready1, f1, busy1, valid1;
    logic [6:0]   x1;
    logic [127:0] tt1;
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
    logic [7:0]   ones0, ones1;
`endif

    int mode;
    int n_assert;
    int n_fail;
    int lat;

    localparam logic [127:0] TT_X0   = {64{2'b10}};
    localparam logic [127:0] TT_AND  = {1'b1, 127'b0};
    localparam logic [127:0] TT_X6   = {{64{1'b1}}, {64{1'b0}}};

    tt_sweep_capture dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .busy     (busy0),
        .x_o      (x0),
        .f_i      (f0),
        .tt_o     (tt0),
        .tt_valid (valid0),
        .tt_ready (ready0)
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
        ,
        .ones_o   (ones0)
`endif
    );

    tt_sweep_capture #(.NIN(7), .SETTLE(3)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .busy     (busy1),
        .x_o      (x1),
        .f_i      (f1),
        .tt_o     (tt1),
        .tt_valid (valid1),
        .tt_ready (ready1)
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
        ,
        .ones_o   (ones1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            0:       f0 = x0[0];
            1:       f0 = &x0;
            2:       f0 = 1'b0;
            default: f0 = x0[6];
        endcase
    end
    assign f1 = x1[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start, then count edges until tt_valid; p1/p2 re-pulse start mid-run.
    task automatic sweep0(input int p1, input int p2, output int n);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 0;
        while (!valid0 && n < 2000) begin
            start0 = (n == p1) || (n == p2);
            tick();
            n++;
        end
        start0 = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        mode     = 0;
        rst_n    = 1'b0;
        start0   = 1'b0;
        ready0   = 1'b1;
        start1   = 1'b0;
        ready1   = 1'b1;
        #12;
        check("rst_tt",    tt0,            '0);
        check("rst_valid", 128'(valid0),   '0);
        check("rst_busy",  128'(busy0),    '0);
        check("rst_x",     128'(x0),       '0);
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
        check("rst_ones",  128'(ones0),    '0);
`endif
        rst_n = 1'b1;
        tick();

        // f = x0
        mode = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("x0_busy_first", 128'(busy0), 128'(1));
        check("x0_x_first",    128'(x0),    '0);
        lat = 0;
        while (!valid0 && lat < 2000) begin
            tick();
            lat++;
        end
        check("x0_latency", 128'(lat), 128'(128));
        check("x0_tt",      tt0,       TT_X0);
        check("x0_x_hold",  128'(x0),  '0);
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
        check("x0_ones",    128'(ones0), 128'(64));
`endif
        tick();
        check("x0_valid_drop", 128'(valid0), '0);
        check("x0_busy_drop",  128'(busy0),  '0);
        check("x0_tt_kept",    tt0,          TT_X0);

        // f = AND of all inputs
        mode = 1;
        sweep0(-1, -1, lat);
        check("and_latency", 128'(lat), 128'(128));
        check("and_tt",      tt0,       TT_AND);
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
        check("and_ones",    128'(ones0), 128'(1));
`endif
        tick();

        // f = 0
        mode = 2;
        sweep0(-1, -1, lat);
        check("zero_tt", tt0, '0);
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
        check("zero_ones", 128'(ones0), '0);
`endif
        tick();

        // start pulses at idx 10 and 100 must not restart the sweep
        mode = 0;
        sweep0(10, 100, lat);
        check("restart_latency", 128'(lat), 128'(128));
        check("restart_tt",      tt0,       TT_X0);
        tick();

        // backpressure in HOLD, with a stray start
        mode = 1;
        ready0 = 1'b0;
        sweep0(-1, -1, lat);
        for (int c = 0; c < 10; c++) begin
            start0 = (c == 3);
            tick();
            check("bp_valid", 128'(valid0), 128'(1));
            check("bp_tt",    tt0,          TT_AND);
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        tick();
        check("bp_release_valid", 128'(valid0), '0);
        check("bp_release_busy",  128'(busy0),  '0);
        mode = 2;
        sweep0(-1, -1, lat);
        check("bp_fresh_latency", 128'(lat), 128'(128));
        check("bp_fresh_tt",      tt0,       '0);

        // start during the handshake cycle is dropped
        ready0 = 1'b0;
        tick();
        check("hs_valid_held", 128'(valid0), 128'(1));
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("hs_busy_after", 128'(busy0), '0);
        tick();
        check("hs_busy_next",  128'(busy0), '0);

        // reset mid-sweep at idx 50
        mode = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 0; c < 50; c++) tick();
        check("mid_x_at50", 128'(x0), 128'(50));
        rst_n = 1'b0;
        #1;
        check("mid_rst_x",     128'(x0),     '0);
        check("mid_rst_busy",  128'(busy0),  '0);
        check("mid_rst_valid", 128'(valid0), '0);
        check("mid_rst_tt",    tt0,          '0);
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
        check("mid_rst_ones",  128'(ones0),  '0);
`endif
        #2;
        rst_n = 1'b1;
        tick();
        check("mid_idle_valid", 128'(valid0), '0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("mid_restart_x", 128'(x0), '0);
        tick();
        check("mid_restart_x1", 128'(x0), 128'(1));
        lat = 1;
        while (!valid0 && lat < 2000) begin
            tick();
            lat++;
        end
        check("mid_latency", 128'(lat), 128'(128));
        check("mid_tt",      tt0,       TT_X0);
        tick();

        // SETTLE=3 instance, f = x6
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        lat = 0;
        check("s3_x_0", 128'(x1), '0);
        while (!valid1 && lat < 4000) begin
            tick();
            lat++;
            if (lat == 3)  check("s3_x_3",  128'(x1), 128'(0));
            if (lat == 4)  check("s3_x_4",  128'(x1), 128'(1));
            if (lat == 7)  check("s3_x_7",  128'(x1), 128'(1));
            if (lat == 8)  check("s3_x_8",  128'(x1), 128'(2));
        end
        check("s3_latency", 128'(lat), 128'(512));
        check("s3_tt",      tt1,       TT_X6);
`ifdef TT_SWEEP_CAPTURE_POPCOUNT_EN
        check("s3_ones",    128'(ones1), 128'(64));
`endif
        tick();
        check("s3_valid_drop", 128'(valid1), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Exhaustive truth-table capture stage for the 7-input classification flow. On a start pulse it walks all 2^NIN input vectors in ascending order, drives each onto the input pins of a combinational majority-logic function, and samples the function's single output into a 2^NIN-bit truth table. The finished table is presented downstream with a valid/ready handshake for classification. The block is both the stimulus source directly upstream of the function under evaluation and the consumer of its output.

## Interface

Parameters:
- NIN, default 7: number of function inputs. Legal range 2..8.
- SETTLE, default 0: extra wait cycles after a vector is driven, before it is sampled. Legal range 0..15.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- clk, in, 1: clock. All state changes on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: sweep request. Sampled only in IDLE.
- busy, out, 1: high in RUN and HOLD.
- x_o, out, NIN: input vector driven to the function. x_o[0] maps to x0.
- f_i, in, 1: function output, combinational from x_o.
- tt_o, out, 2**NIN: truth table. Bit i holds f at x_o == i.
- tt_valid, out, 1: tt_o is complete and stable.
- tt_ready, in, 1: downstream accepts the table.
- ones_o, out, NIN+1: count of 1 bits in tt_o. Only with the macro; see Configuration.

## Operation

- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - On start=1: clear tt_o, idx, wait and ones to 0, then enter RUN. x_o is 0 in the first RUN cycle.
  - Otherwise stay in IDLE.
- RUN:
  - x_o is registered and equal to idx.
  - When wait != SETTLE: wait increments.
  - When wait == SETTLE: tt_o[idx] <= f_i, wait <= 0, idx <= idx+1.
  - When the last index, 2^NIN−1, is sampled: enter HOLD and set tt_valid.
  - idx wraps to 0 on that same sample.
- HOLD:
  - tt_valid=1, tt_o and ones_o stable, start ignored.
  - On tt_valid & tt_ready: clear tt_valid, go to IDLE.
- Values in IDLE:
  - x_o returns to 0.
  - tt_o keeps its last table until the next start.
- Reset values: tt_o=0, tt_valid=0, busy=0, x_o=0, ones_o=0, state IDLE.
- Boundaries:
  - start while busy: ignored, not queued.
  - start in the handshake cycle: ignored. A new start is accepted one cycle later, in IDLE.
  - rst_n low mid-sweep or in HOLD: immediate abort to reset values. No partial table is flagged valid.
  - tt_ready while not valid: no effect.

## Timing

- Cycles per vector: SETTLE+1. RUN length: 2^NIN·(SETTLE+1) cycles.
- Latency: tt_valid rises 2^NIN·(SETTLE+1) edges after the edge that accepts start. This is 128 edges at the defaults.
- The sample of vector i is taken at the end of the last cycle in which x_o == i.
- tt_valid and busy deassert on the edge after the handshake.
- Minimum start-to-start period: latency + 1 (handshake cycle) + 1 (IDLE).

## Configuration

- Macro: TT_SWEEP_CAPTURE_POPCOUNT_EN.
- Defined:
  - ones_o port exists.
  - An NIN+1-bit counter increments on each sample where f_i=1.
  - It is cleared on start and is valid together with tt_valid.
- Undefined: ones_o and its counter are absent. All other behaviour is identical.

## Structure

- Shared package tt_sweep_pkg holds:
  - the state enum (IDLE, RUN, HOLD);
  - the default NIN and SETTLE constants;
  - a SETTLE_W width constant equal to 4.
- One sub-module, tt_sweep_fsm, holds state, idx and the wait counter. It emits a sample strobe, a last strobe, x_o and busy.
- The top level holds the tt_o capture register, the handshake and the optional popcount.

## Test plan

- f_i = x_o[0], defaults, tt_ready=1 → tt_o = 128'hAAAA…AAAA, ones_o=64, tt_valid 128 cycles after start.
- f_i = AND of all x_o bits → tt_o = 1<<127, ones_o=1. f_i=0 constant → tt_o=0, ones_o=0.
- SETTLE=3, f_i = x_o[6] → tt_o = upper 64 bits 1 and lower 64 bits 0; tt_valid 512 cycles after start; each x_o value is held for 4 cycles.
- Backpressure:
  - hold tt_ready=0 for 10 cycles in HOLD → tt_valid and tt_o stable, a start pulse is ignored;
  - raise tt_ready → IDLE on the next edge;
  - a start 1 cycle later runs a fresh sweep.
- Reset mid-sweep: assert rst_n=0 at idx=50 → all outputs 0 immediately; the next start sweeps from x_o=0.
- start pulses during RUN at idx 10 and 100 → no restart; final table unaffected.
